wb_port_arbiter: RTL and testbench

// - Shares the single register-file write port between two producers.
//   - The in-order pipeline writeback (WB stage) always owns the port on its cycles.
//   - A long-latency unit (LU, e.g. MUL/DIV) produces results out of band.
// - LU results that collide with a pipeline write wait in a 1-entry hold register.
// - After STARVE_LIMIT waiting cycles the block stalls the pipeline for one cycle to drain the held entry.
// - Sits between WB_STAGE and the DE-stage register file; drives the rf write bundle.

---
 rtl/wb_port_arbiter_pkg.sv | 29 ++
 rtl/wb_arb_hold_reg.sv | 38 +++
 rtl/wb_port_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared widths, FSM state encoding and port-select codes
// for the writeback-port arbiter and its hold register.
package wb_port_arbiter_pkg;

    localparam int REGNOBITS  = 5;
    localparam int DBITS      = 32;
    localparam int STATE_BITS = 2;

    // EMPTY: nothing waiting, HELD: one LU result parked, FORCE: stall-and-drain cycle
    typedef enum logic [STATE_BITS-1:0] {
        ST_EMPTY = 2'd0,
        ST_HELD  = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_t;

    // Which producer owns the register-file write port this cycle
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_PIPE = 2'd1,
        SEL_HOLD = 2'd2,
        SEL_LU   = 2'd3
    } sel_t;

    // x0 is hard-wired to zero, so writes to it are never performed
    function automatic logic is_x0(input logic [REGNOBITS-1:0] regno);
        return regno == '0;
    endfunction

endpackage

// File: rtl/wb_arb_hold_reg.sv
// wb_arb_hold_reg: one-entry parking register for an LU result that lost the
// write port to the pipeline. A younger pipeline write to the same register
// invalidates the entry so the stale LU value can never land afterwards.
import wb_port_arbiter_pkg::*;

module wb_arb_hold_reg (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [REGNOBITS-1:0] load_regno,
    input  logic [DBITS-1:0]     load_val,
    input  logic                 clear,
    input  logic                 inval_en,
    input  logic [REGNOBITS-1:0] inval_regno,
    output logic                 valid,
    output logic [REGNOBITS-1:0] regno,
    output logic [DBITS-1:0]     val,
    output logic                 match
);

    assign match = valid & inval_en & (inval_regno == regno);

    // Entry storage: drain/invalidate take priority over loading a new result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            regno <= '0;
            val   <= '0;
        end else if (clear || match) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            regno <= load_regno;
            val   <= load_val;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the
// in-order WB stage and an out-of-band long-latency unit. A colliding LU result
// is parked in a one-entry hold register and forcibly drained (one-cycle
// pipeline stall) once it has waited STARVE_LIMIT cycles.
// Optional statistics counters are compiled in with `define WB_ARB_STATS_EN.
import wb_port_arbiter_pkg::*;

module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNTBITS      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pipe_wr_i,
    input  logic [REGNOBITS-1:0] pipe_regno_i,
    input  logic [DBITS-1:0]     pipe_val_i,
    input  logic                 lu_valid_i,
    output logic                 lu_ready_o,
    input  logic [REGNOBITS-1:0] lu_regno_i,
    input  logic [DBITS-1:0]     lu_val_i,
    output logic                 pipe_stall_o,
    output logic                 rf_wr_o,
    output logic [REGNOBITS-1:0] rf_regno_o,
    output logic [DBITS-1:0]     rf_val_o,
    output logic                 hold_valid_o,
    output logic [REGNOBITS-1:0] hold_regno_o
`ifdef WB_ARB_STATS_EN
   ,output logic [31:0]          stat_held_o,
    output logic [31:0]          stat_forced_o,
    output logic [31:0]          stat_dropped_o
`endif
);

    arb_state_t           state;
    arb_state_t           next_state;
    sel_t                 sel;
    logic                 fire;
    logic                 lu_is_x0;
    logic                 lu_same_reg;
    logic                 starved;
    logic                 hold_load;
    logic                 hold_clear;
    logic                 inval_en;
    logic                 hold_match;
    logic                 hold_valid;
    logic [REGNOBITS-1:0] hold_regno;
    logic [DBITS-1:0]     hold_val;
    logic [CNTBITS-1:0]   wait_cnt;
    logic                 wr_en;
    logic [REGNOBITS-1:0] wr_regno;
    logic [DBITS-1:0]     wr_val;

    // Ready comes purely from registered state so there is no loop through lu_valid_i
    assign lu_ready_o   = ~hold_valid;
    assign fire         = lu_valid_i & lu_ready_o;
    assign lu_is_x0     = is_x0(lu_regno_i);
    assign lu_same_reg  = (lu_regno_i == pipe_regno_i);
    assign starved      = (wait_cnt == CNTBITS'(STARVE_LIMIT - 1));
    assign inval_en     = pipe_wr_i & (state == ST_HELD);
    assign hold_valid_o = hold_valid;
    assign hold_regno_o = hold_regno;

    wb_arb_hold_reg u_hold (
        .clk         (clk),
        .reset       (reset),
        .load        (hold_load),
        .load_regno  (lu_regno_i),
        .load_val    (lu_val_i),
        .clear       (hold_clear),
        .inval_en    (inval_en),
        .inval_regno (pipe_regno_i),
        .valid       (hold_valid),
        .regno       (hold_regno),
        .val         (hold_val),
        .match       (hold_match)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state: park on collision, force-drain when starved, empty on drain or WAW kill
    always_comb begin
        next_state = state;
        case (state)
            ST_EMPTY: begin
                if (pipe_wr_i && fire && !lu_is_x0 && !lu_same_reg) begin
                    next_state = ST_HELD;
                end
            end
            ST_HELD: begin
                if (!pipe_wr_i || hold_match) begin
                    next_state = ST_EMPTY;
                end else if (starved) begin
                    next_state = ST_FORCE;
                end
            end
            ST_FORCE: begin
                next_state = ST_EMPTY;
            end
            default: begin
                next_state = ST_EMPTY;
            end
        endcase
    end

    // FSM outputs: port owner selection in priority FORCE > pipeline > held > LU bypass
    always_comb begin
        sel          = SEL_NONE;
        hold_load    = 1'b0;
        hold_clear   = 1'b0;
        pipe_stall_o = 1'b0;
        case (state)
            ST_FORCE: begin
                sel          = SEL_HOLD;
                hold_clear   = 1'b1;
                pipe_stall_o = 1'b1;
            end
            ST_HELD: begin
                if (pipe_wr_i) begin
                    sel = SEL_PIPE;
                end else begin
                    sel        = SEL_HOLD;
                    hold_clear = 1'b1;
                end
            end
            ST_EMPTY: begin
                if (pipe_wr_i) begin
                    sel = SEL_PIPE;
                    if (fire && !lu_is_x0 && !lu_same_reg) begin
                        hold_load = 1'b1;
                    end
                end else if (fire) begin
                    sel = SEL_LU;
                end
            end
            default: begin
                sel = SEL_NONE;
            end
        endcase
    end

    // Write-port data mux feeding the registered rf outputs
    always_comb begin
        wr_en    = 1'b0;
        wr_regno = '0;
        wr_val   = '0;
        case (sel)
            SEL_PIPE: begin
                wr_en    = 1'b1;
                wr_regno = pipe_regno_i;
                wr_val   = pipe_val_i;
            end
            SEL_HOLD: begin
                wr_en    = 1'b1;
                wr_regno = hold_regno;
                wr_val   = hold_val;
            end
            SEL_LU: begin
                wr_en    = 1'b1;
                wr_regno = lu_regno_i;
                wr_val   = lu_val_i;
            end
            default: begin
                wr_en    = 1'b0;
            end
        endcase
    end

    // Wait counter: counts cycles spent parked, restarts whenever the entry leaves HELD
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == ST_HELD && next_state == ST_HELD) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Register-file write bundle, one cycle after selection; x0 writes are squashed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_wr_o    <= 1'b0;
            rf_regno_o <= '0;
            rf_val_o   <= '0;
        end else begin
            rf_wr_o    <= wr_en & !is_x0(wr_regno);
            rf_regno_o <= wr_regno;
            rf_val_o   <= wr_val;
        end
    end

`ifdef WB_ARB_STATS_EN
    logic waw_drop;

    // A WAW drop is either a parked entry killed by a younger write or a same-register collision
    assign waw_drop = ((state == ST_HELD) & hold_match) |
                      ((state == ST_EMPTY) & pipe_wr_i & fire & !lu_is_x0 & lu_same_reg);

    // Saturating event counters for parked results, forced drains and WAW drops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_held_o    <= '0;
            stat_forced_o  <= '0;
            stat_dropped_o <= '0;
        end else begin
            if (hold_load && stat_held_o != '1) begin
                stat_held_o <= stat_held_o + 1'b1;
            end
            if (state == ST_FORCE && stat_forced_o != '1) begin
                stat_forced_o <= stat_forced_o + 1'b1;
            end
            if (waw_drop && stat_dropped_o != '1) begin
                stat_dropped_o <= stat_dropped_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed table of single-cycle vectors for the arbiter,
// followed by hand-written starvation and mid-operation reset sequences.
module tb_wb_port_arbiter;

    logic        clk;
    logic        reset;
    logic        pipe_wr_i;
    logic [4:0]  pipe_regno_i;
    logic [31:0] pipe_val_i;
    logic        lu_valid_i;
    logic        lu_ready_o;
    logic [4:0]  lu_regno_i;
    logic [31:0] lu_val_i;
    logic        pipe_stall_o;
    logic        rf_wr_o;
    logic [4:0]  rf_regno_o;
    logic [31:0] rf_val_o;
    logic        hold_valid_o;
    logic [4:0]  hold_regno_o;

    int n_applied;
    int n_miscompares;

    typedef struct {
        logic        pipe_wr;
        logic [4:0]  pipe_regno;
        logic [31:0] pipe_val;
        logic        lu_valid;
        logic [4:0]  lu_regno;
        logic [31:0] lu_val;
        logic        exp_wr;
        logic [4:0]  exp_regno;
        logic [31:0] exp_val;
        logic        exp_hold;
        logic [4:0]  exp_hold_regno;
        logic        exp_ready;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];

    wb_port_arbiter #(
        .STARVE_LIMIT (8),
        .CNTBITS      (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pipe_wr_i    (pipe_wr_i),
        .pipe_regno_i (pipe_regno_i),
        .pipe_val_i   (pipe_val_i),
        .lu_valid_i   (lu_valid_i),
        .lu_ready_o   (lu_ready_o),
        .lu_regno_i   (lu_regno_i),
        .lu_val_i     (lu_val_i),
        .pipe_stall_o (pipe_stall_o),
        .rf_wr_o      (rf_wr_o),
        .rf_regno_o   (rf_regno_o),
        .rf_val_o     (rf_val_o),
        .hold_valid_o (hold_valid_o),
        .hold_regno_o (hold_regno_o)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no $finish, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_applied++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and sample #1 after the rising edge
    task automatic applyStimulus(input logic pw, input logic [4:0] pr, input logic [31:0] pv,
                                 input logic lv, input logic [4:0] lr, input logic [31:0] lval);
        @(negedge clk);
        pipe_wr_i    = pw;
        pipe_regno_i = pr;
        pipe_val_i   = pv;
        lu_valid_i   = lv;
        lu_regno_i   = lr;
        lu_val_i     = lval;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_applied     = 0;
        n_miscompares = 0;

        //            pw  pr     pv      lv  lr      lval    ew  er      ev      eh  ehr     rdy
        vecs[0]  = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd5,  32'h11, 1'b1, 5'd5,  32'h11, 1'b0, 5'd0,  1'b1};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  1'b1};
        vecs[2]  = '{1'b1, 5'd3,  32'hA,  1'b1, 5'd7,  32'hB,  1'b1, 5'd3,  32'hA,  1'b1, 5'd7,  1'b0};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b1, 5'd7,  32'hB,  1'b0, 5'd0,  1'b1};
        vecs[4]  = '{1'b1, 5'd4,  32'h44, 1'b1, 5'd9,  32'h99, 1'b1, 5'd4,  32'h44, 1'b1, 5'd9,  1'b0};
        vecs[5]  = '{1'b1, 5'd9,  32'h55, 1'b0, 5'd0,  32'h0,  1'b1, 5'd9,  32'h55, 1'b0, 5'd0,  1'b1};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  1'b1};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd0,  32'h77, 1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  1'b1};
        vecs[8]  = '{1'b1, 5'd2,  32'h22, 1'b1, 5'd0,  32'h33, 1'b1, 5'd2,  32'h22, 1'b0, 5'd0,  1'b1};
        vecs[9]  = '{1'b1, 5'd6,  32'h66, 1'b1, 5'd6,  32'h67, 1'b1, 5'd6,  32'h66, 1'b0, 5'd0,  1'b1};
        vecs[10] = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  1'b1};
        vecs[11] = '{1'b1, 5'd0,  32'h12, 1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  1'b1};
        vecs[12] = '{1'b1, 5'd1,  32'h1,  1'b1, 5'd8,  32'h88, 1'b1, 5'd1,  32'h1,  1'b1, 5'd8,  1'b0};
        vecs[13] = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd10, 32'hAA, 1'b1, 5'd8,  32'h88, 1'b0, 5'd0,  1'b1};
        vecs[14] = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd10, 32'hAA, 1'b1, 5'd10, 32'hAA, 1'b0, 5'd0,  1'b1};
        vecs[15] = '{1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  32'h0,  1'b0, 5'd0,  1'b1};

        reset        = 1'b1;
        pipe_wr_i    = 1'b0;
        pipe_regno_i = '0;
        pipe_val_i   = '0;
        lu_valid_i   = 1'b0;
        lu_regno_i   = '0;
        lu_val_i     = '0;
        repeat (2) @(negedge clk);

        checkOutput("reset rf_wr", 32'(rf_wr_o), 32'd0);
        checkOutput("reset rf_regno", 32'(rf_regno_o), 32'd0);
        checkOutput("reset rf_val", rf_val_o, 32'd0);
        checkOutput("reset hold_valid", 32'(hold_valid_o), 32'd0);
        checkOutput("reset stall", 32'(pipe_stall_o), 32'd0);
        checkOutput("reset lu_ready", 32'(lu_ready_o), 32'd1);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].pipe_wr, vecs[i].pipe_regno, vecs[i].pipe_val,
                          vecs[i].lu_valid, vecs[i].lu_regno, vecs[i].lu_val);
            checkOutput($sformatf("v%0d rf_wr", i), 32'(rf_wr_o), 32'(vecs[i].exp_wr));
            if (vecs[i].exp_wr) begin
                checkOutput($sformatf("v%0d rf_regno", i), 32'(rf_regno_o), 32'(vecs[i].exp_regno));
                checkOutput($sformatf("v%0d rf_val", i), rf_val_o, vecs[i].exp_val);
            end
            checkOutput($sformatf("v%0d hold_valid", i), 32'(hold_valid_o), 32'(vecs[i].exp_hold));
            if (vecs[i].exp_hold) begin
                checkOutput($sformatf("v%0d hold_regno", i), 32'(hold_regno_o), 32'(vecs[i].exp_hold_regno));
            end
            checkOutput($sformatf("v%0d lu_ready", i), 32'(lu_ready_o), 32'(vecs[i].exp_ready));
            checkOutput($sformatf("v%0d stall", i), 32'(pipe_stall_o), 32'd0);
        end

        // Starvation: park x12 then keep the pipeline writing every cycle
        applyStimulus(1'b1, 5'd1, 32'h100, 1'b1, 5'd12, 32'hC0);
        checkOutput("starve park hold_valid", 32'(hold_valid_o), 32'd1);
        checkOutput("starve park stall", 32'(pipe_stall_o), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 5'(i + 1), 32'h1000 + 32'(i), 1'b0, 5'd0, 32'h0);
            checkOutput($sformatf("starve w%0d rf_wr", i), 32'(rf_wr_o), 32'd1);
            checkOutput($sformatf("starve w%0d rf_regno", i), 32'(rf_regno_o), 32'(i + 1));
            checkOutput($sformatf("starve w%0d rf_val", i), rf_val_o, 32'h1000 + 32'(i));
            checkOutput($sformatf("starve w%0d hold_valid", i), 32'(hold_valid_o), 32'd1);
            checkOutput($sformatf("starve w%0d stall", i), 32'(pipe_stall_o), (i == 8) ? 32'd1 : 32'd0);
        end
        // FORCE cycle: the pipeline's x20 write is ignored and the parked entry lands
        applyStimulus(1'b1, 5'd20, 32'h2020, 1'b0, 5'd0, 32'h0);
        checkOutput("force rf_wr", 32'(rf_wr_o), 32'd1);
        checkOutput("force rf_regno", 32'(rf_regno_o), 32'd12);
        checkOutput("force rf_val", rf_val_o, 32'hC0);
        checkOutput("force stall released", 32'(pipe_stall_o), 32'd0);
        checkOutput("force hold_valid", 32'(hold_valid_o), 32'd0);
        checkOutput("force lu_ready", 32'(lu_ready_o), 32'd1);
        // The replayed pipeline write now goes through
        applyStimulus(1'b1, 5'd20, 32'h2020, 1'b0, 5'd0, 32'h0);
        checkOutput("replay rf_regno", 32'(rf_regno_o), 32'd20);
        checkOutput("replay rf_val", rf_val_o, 32'h2020);
        checkOutput("replay stall", 32'(pipe_stall_o), 32'd0);

        // Reset while HELD discards the parked entry immediately
        applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd14, 32'hE0);
        checkOutput("prereset hold_valid", 32'(hold_valid_o), 32'd1);
        checkOutput("prereset hold_regno", 32'(hold_regno_o), 32'd14);
        @(negedge clk);
        pipe_wr_i  = 1'b0;
        lu_valid_i = 1'b0;
        reset      = 1'b1;
        #1;
        checkOutput("midreset rf_wr", 32'(rf_wr_o), 32'd0);
        checkOutput("midreset rf_regno", 32'(rf_regno_o), 32'd0);
        checkOutput("midreset rf_val", rf_val_o, 32'd0);
        checkOutput("midreset hold_valid", 32'(hold_valid_o), 32'd0);
        checkOutput("midreset stall", 32'(pipe_stall_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkOutput("postreset rf_wr", 32'(rf_wr_o), 32'd0);
        checkOutput("postreset lu_ready", 32'(lu_ready_o), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'hB1);
        checkOutput("postreset lu rf_wr", 32'(rf_wr_o), 32'd1);
        checkOutput("postreset lu rf_regno", 32'(rf_regno_o), 32'd11);
        checkOutput("postreset lu rf_val", rf_val_o, 32'hB1);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
